pr_hrav_rr_arb: RTL and testbench

- Packet-aware round-robin arbiter that shares one downstream stream interface (typically the dispatcher's double buffer) between NUM_REQ upstream requesters.
- Grant is locked for the duration of a packet: first beat through the beat flagged last.
- The datapath mux is combinational from a registered grant, so output valid, data and last come from the selected requester.
- Also exports grant and busy status plus a free-running packet counter.

---
 rtl/pr_hrav_rr_arb.sv | 126 ++++++++++++
 tb/tb_pr_hrav_rr_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pr_hrav_rr_arb.sv
// Packet-aware round-robin arbiter: one downstream stream shared by NUM_REQ requesters,
// with the grant held from the first beat through the beat flagged last.
module pr_hrav_rr_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DAT_BW  = 128,
    parameter int unsigned IDX_BW  = 2,
    parameter int unsigned CNT_BW  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        vld_in,
    input  logic [NUM_REQ*DAT_BW-1:0] data_in,
    input  logic [NUM_REQ-1:0]        last_in,
    output logic [NUM_REQ-1:0]        ready_out,
    input  logic                      ready_in,
    output logic                      vld_out,
    output logic [DAT_BW-1:0]         data_out,
    output logic                      last_out,
    output logic [IDX_BW-1:0]         grant_idx,
    output logic                      busy,
    output logic [CNT_BW-1:0]         pkt_cnt
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StBusy = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [IDX_BW-1:0] grant_q, grant_d;
    logic [IDX_BW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_BW-1:0] pkt_cnt_q, pkt_cnt_d;

    logic [NUM_REQ-1:0] vld_rot;
    logic               arb_found;
    logic [IDX_BW-1:0]  arb_idx;
    int unsigned        arb_cand;

    logic               sel_vld;
    logic               sel_last;
    logic [DAT_BW-1:0]  sel_data;
    logic               in_busy;
    logic               pkt_end;

    assign in_busy = (state_q == StBusy);

    // Rotate so bit 0 is the requester at rr_ptr; the first set bit upward wins.
    assign vld_rot = NUM_REQ'({vld_in, vld_in} >> rr_ptr_q);

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!arb_found && vld_rot[k]) begin
                arb_found = 1'b1;
                arb_cand  = (32'(rr_ptr_q) + k) % NUM_REQ;
                arb_idx   = IDX_BW'(arb_cand);
            end
        end
    end

    // Datapath select from the registered grant only.
    always_comb begin
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q == IDX_BW'(i)) begin
                sel_vld  = vld_in[i];
                sel_last = last_in[i];
                sel_data = data_in[i*DAT_BW +: DAT_BW];
            end
        end
    end

    always_comb begin
        ready_out = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (in_busy && (grant_q == IDX_BW'(i))) begin
                ready_out[i] = ready_in;
            end
        end
    end

    assign pkt_end = in_busy && sel_vld && ready_in && sel_last;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        if (state_q == StIdle) begin
            if (arb_found) begin
                grant_d = arb_idx;
                state_d = StBusy;
            end
        end else begin
            if (pkt_end) begin
                state_d   = StIdle;
                rr_ptr_d  = (grant_q == IDX_BW'(NUM_REQ - 1)) ? '0 : grant_q + IDX_BW'(1);
                pkt_cnt_d = pkt_cnt_q + CNT_BW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign vld_out   = in_busy && sel_vld;
    assign last_out  = in_busy && sel_last;
    assign data_out  = sel_data;
    assign grant_idx = grant_q;
    assign busy      = in_busy;
    assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_pr_hrav_rr_arb.sv
// Directed bench for pr_hrav_rr_arb: packet locking, round-robin order, stalls, gaps,
// mid-packet reset and packet-counter wrap.
module tb_pr_hrav_rr_arb;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DAT_BW  = 16;
    localparam int unsigned IDX_BW  = 2;
    localparam int unsigned CNT_BW  = 4;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        vld_in;
    logic [NUM_REQ*DAT_BW-1:0] data_in;
    logic [NUM_REQ-1:0]        last_in;
    logic [NUM_REQ-1:0]        ready_out;
    logic                      ready_in;
    logic                      vld_out;
    logic [DAT_BW-1:0]         data_out;
    logic                      last_out;
    logic [IDX_BW-1:0]         grant_idx;
    logic                      busy;
    logic [CNT_BW-1:0]         pkt_cnt;

    logic [DAT_BW-1:0] d0, d1, d2, d3;
    assign data_in = {d3, d2, d1, d0};

    int total = 0;
    int bad   = 0;
    logic [1:0] ord [6];

    pr_hrav_rr_arb #(
        .NUM_REQ(NUM_REQ),
        .DAT_BW (DAT_BW),
        .IDX_BW (IDX_BW),
        .CNT_BW (CNT_BW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .vld_in   (vld_in),
        .data_in  (data_in),
        .last_in  (last_in),
        .ready_out(ready_out),
        .ready_in (ready_in),
        .vld_out  (vld_out),
        .data_out (data_out),
        .last_out (last_out),
        .grant_idx(grant_idx),
        .busy     (busy),
        .pkt_cnt  (pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ord = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rst = 1'b1; vld_in = '0; last_in = '0; ready_in = 1'b0;
        d0 = 16'h0A01; d1 = 16'h1001; d2 = 16'h2001; d3 = 16'h3001;
        tick(); tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vld", 32'(vld_out), 32'd0);
        chk("rst_last", 32'(last_out), 32'd0);
        chk("rst_ready", 32'(ready_out), 32'd0);
        chk("rst_grant", 32'(grant_idx), 32'd0);
        chk("rst_cnt", 32'(pkt_cnt), 32'd0);
        chk("rst_data", 32'(data_out), 32'h0A01);
        rst = 1'b0;

        // 3-beat packet from requester 2
        tick();
        vld_in = 4'b0100; ready_in = 1'b1; #1;
        chk("t1_idle_vld", 32'(vld_out), 32'd0);
        chk("t1_idle_ready", 32'(ready_out), 32'd0);
        tick();
        chk("t1_grant", 32'(grant_idx), 32'd2);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_b1_vld", 32'(vld_out), 32'd1);
        chk("t1_b1_data", 32'(data_out), 32'h2001);
        chk("t1_ready", 32'(ready_out), 32'b0100);
        chk("t1_b1_last", 32'(last_out), 32'd0);
        tick();
        d2 = 16'h2002; #1;
        chk("t1_b2_data", 32'(data_out), 32'h2002);
        chk("t1_b2_busy", 32'(busy), 32'd1);
        tick();
        d2 = 16'h2003; last_in = 4'b0100; #1;
        chk("t1_b3_data", 32'(data_out), 32'h2003);
        chk("t1_b3_last", 32'(last_out), 32'd1);
        tick();
        vld_in = '0; last_in = '0; #1;
        chk("t1_end_busy", 32'(busy), 32'd0);
        chk("t1_end_cnt", 32'(pkt_cnt), 32'd1);
        chk("t1_end_grant", 32'(grant_idx), 32'd2);
        chk("t1_end_vld", 32'(vld_out), 32'd0);
        // rr_ptr=3: with 2 and 3 requesting, 3 must win
        vld_in = 4'b1100; last_in = 4'b1100; #1;
        tick();
        chk("t1_rrptr_grant", 32'(grant_idx), 32'd3);
        tick();
        vld_in = '0; last_in = '0; #1;
        chk("t1_rr_cnt", 32'(pkt_cnt), 32'd2);

        // All requesting, single-beat packets
        vld_in = 4'b1111; last_in = 4'b1111; d0 = 16'h0A01; d1 = 16'h1001; d3 = 16'h3001;
        #1;
        for (int p = 0; p < 6; p++) begin
            tick();
            chk("t2_grant", 32'(grant_idx), 32'(ord[p]));
            chk("t2_busy", 32'(busy), 32'd1);
            chk("t2_ready", 32'(ready_out), 32'd1 << ord[p]);
            tick();
            chk("t2_bubble", 32'(busy), 32'd0);
        end
        chk("t2_cnt", 32'(pkt_cnt), 32'd8);

        // Requester 3 granted, downstream stall mid-packet
        vld_in = 4'b1000; last_in = '0; #1;
        tick();
        chk("t3_grant", 32'(grant_idx), 32'd3);
        tick();
        vld_in = 4'b1111; d3 = 16'h3002; ready_in = 1'b0; #1;
        for (int s = 0; s < 5; s++) begin
            chk("t3_stall_ready", 32'(ready_out), 32'd0);
            chk("t3_stall_grant", 32'(grant_idx), 32'd3);
            tick();
        end
        chk("t3_stall_busy", 32'(busy), 32'd1);
        ready_in = 1'b1; last_in = 4'b1000; #1;
        chk("t3_resume_ready", 32'(ready_out), 32'b1000);
        chk("t3_resume_last", 32'(last_out), 32'd1);
        chk("t3_resume_data", 32'(data_out), 32'h3002);
        tick();
        chk("t3_end_busy", 32'(busy), 32'd0);
        chk("t3_end_cnt", 32'(pkt_cnt), 32'd9);
        tick();
        chk("t3_wrap_grant", 32'(grant_idx), 32'd0);
        last_in = 4'b0001; #1;
        tick();
        vld_in = 4'b0010; last_in = '0; #1;
        chk("t3_p0_cnt", 32'(pkt_cnt), 32'd10);

        // Requester 1 with a 2-cycle valid gap
        tick();
        chk("t4_grant", 32'(grant_idx), 32'd1);
        chk("t4_b1_vld", 32'(vld_out), 32'd1);
        chk("t4_b1_data", 32'(data_out), 32'h1001);
        tick();
        vld_in = 4'b1101; #1;
        chk("t4_gap_vld", 32'(vld_out), 32'd0);
        chk("t4_gap_ready", 32'(ready_out), 32'b0010);
        tick();
        chk("t4_gap2_vld", 32'(vld_out), 32'd0);
        chk("t4_gap2_grant", 32'(grant_idx), 32'd1);
        vld_in = 4'b1111; d1 = 16'h1002; last_in = 4'b0010; #1;
        chk("t4_b2_data", 32'(data_out), 32'h1002);
        chk("t4_b2_last", 32'(last_out), 32'd1);
        tick();
        vld_in = '0; last_in = '0; #1;
        chk("t4_end_busy", 32'(busy), 32'd0);
        chk("t4_end_cnt", 32'(pkt_cnt), 32'd11);

        // Reset during beat 2 of requester 0's packet
        vld_in = 4'b0001; #1;
        tick();
        chk("t5_grant", 32'(grant_idx), 32'd0);
        tick();
        d0 = 16'h0A02; #1;
        chk("t5_b2_vld", 32'(vld_out), 32'd1);
        rst = 1'b1; #1;
        chk("t5_rst_vld", 32'(vld_out), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_cnt", 32'(pkt_cnt), 32'd0);
        tick();
        rst = 1'b0; vld_in = 4'b1010; last_in = 4'b1010; #1;
        tick();
        chk("t5_regrant", 32'(grant_idx), 32'd1);
        tick();
        vld_in = '0; last_in = '0; #1;
        chk("t5_end_cnt", 32'(pkt_cnt), 32'd1);

        // Counter wrap: 14 more packets -> 15, then 0, then 1
        vld_in = 4'b1111; last_in = 4'b1111; #1;
        for (int p = 0; p < 14; p++) begin
            tick(); tick();
        end
        chk("t6_cnt_max", 32'(pkt_cnt), 32'd15);
        tick(); tick();
        chk("t6_cnt_wrap", 32'(pkt_cnt), 32'd0);
        tick(); tick();
        chk("t6_cnt_one", 32'(pkt_cnt), 32'd1);
        vld_in = '0; last_in = '0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
